// File: rtl/decode_stage.sv
// decode_stage: RV64I decoder feeding a 2-entry output FIFO (EMPTY/ONE/TWO occupancy FSM).
// Define RV64M_EN to also decode the RV64M multiply/divide instructions (op_id 33..45).
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [63:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_op,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [63:0] out_imm,
  output logic [63:0] out_pc,
  output logic        out_illegal,
  output logic [31:0] decoded_count
);
`ifdef RV64M_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_U, FMT_J, FMT_S6, FMT_S5} fmt_t;
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic        illegal;
  } ent_t;
  state_t state_q, state_d;
  ent_t ent_q [2];
  ent_t ent_d [2];
  ent_t dec;
  fmt_t fmt;
  logic [5:0] op;
  logic [31:0] cnt_q, cnt_d;
  logic push, pop, slot;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = in_insn[6:0];
  assign f3 = in_insn[14:12];
  assign f7 = in_insn[31:25];
  // op stays 0 (ILLEGAL) for any encoding not matched below, including insn[1:0] != 2'b11
  always_comb begin
    op = 6'd0;
    fmt = FMT_R;
    case (opc)
      7'b0110111: begin op = 6'd1; fmt = FMT_U; end
      7'b0010111: begin op = 6'd2; fmt = FMT_U; end
      7'b1101111: begin op = 6'd3; fmt = FMT_J; end
      7'b1100111: begin op = (f3 == 3'd0) ? 6'd4 : 6'd0; fmt = FMT_I; end
      7'b0010011: begin
        fmt = (f3 == 3'd1 || f3 == 3'd5) ? FMT_S6 : FMT_I;
        case (f3)
          3'd0: op = 6'd5;
          3'd1: op = (f7[6:1] == 6'b000000) ? 6'd11 : 6'd0;
          3'd2: op = 6'd6;
          3'd3: op = 6'd7;
          3'd4: op = 6'd8;
          3'd5: op = (f7[6:1] == 6'b000000) ? 6'd12 : (f7[6:1] == 6'b010000) ? 6'd13 : 6'd0;
          3'd6: op = 6'd9;
          default: op = 6'd10;
        endcase
      end
      7'b0110011: begin
        case (f7)
          7'b0000000: begin
            case (f3)
              3'd0: op = 6'd14;
              3'd1: op = 6'd16;
              3'd2: op = 6'd17;
              3'd3: op = 6'd18;
              3'd4: op = 6'd19;
              3'd5: op = 6'd20;
              3'd6: op = 6'd22;
              default: op = 6'd23;
            endcase
          end
          7'b0100000: op = (f3 == 3'd0) ? 6'd15 : (f3 == 3'd5) ? 6'd21 : 6'd0;
          7'b0000001: op = M_EN ? 6'd33 + {3'd0, f3} : 6'd0;
          default: op = 6'd0;
        endcase
      end
      7'b0011011: begin
        fmt = (f3 == 3'd0) ? FMT_I : FMT_S5;
        op = (f3 == 3'd0) ? 6'd24 :
             (f3 == 3'd1 && f7 == 7'b0000000) ? 6'd25 :
             (f3 == 3'd5 && f7 == 7'b0000000) ? 6'd26 :
             (f3 == 3'd5 && f7 == 7'b0100000) ? 6'd27 : 6'd0;
      end
      7'b0111011: begin
        case (f7)
          7'b0000000: op = (f3 == 3'd0) ? 6'd28 : (f3 == 3'd1) ? 6'd30 : (f3 == 3'd5) ? 6'd31 : 6'd0;
          7'b0100000: op = (f3 == 3'd0) ? 6'd29 : (f3 == 3'd5) ? 6'd32 : 6'd0;
          7'b0000001: op = (!M_EN || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) ? 6'd0 :
                           (f3 == 3'd0) ? 6'd41 : 6'd38 + {3'd0, f3};
          default: op = 6'd0;
        endcase
      end
      default: op = 6'd0;
    endcase
  end
  always_comb begin
    dec.op = op;
    dec.illegal = (op == 6'd0);
    dec.pc = in_pc;
    dec.rd = dec.illegal ? 5'd0 : in_insn[11:7];
    dec.rs1 = (dec.illegal || fmt == FMT_U || fmt == FMT_J) ? 5'd0 : in_insn[19:15];
    dec.rs2 = (!dec.illegal && fmt == FMT_R) ? in_insn[24:20] : 5'd0;
    dec.imm = dec.illegal ? 64'd0 :
              (fmt == FMT_I)  ? {{52{in_insn[31]}}, in_insn[31:20]} :
              (fmt == FMT_U)  ? {{32{in_insn[31]}}, in_insn[31:12], 12'h000} :
              (fmt == FMT_J)  ? {{44{in_insn[31]}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0} :
              (fmt == FMT_S6) ? {58'd0, in_insn[25:20]} :
              (fmt == FMT_S5) ? {59'd0, in_insn[24:20]} : 64'd0;
  end
  assign in_ready = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  // entry 0 is always the oldest; a pop shifts entry 1 down
  always_comb begin
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    slot = (state_q == ONE) && !pop;
    state_d = state_q;
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      state_d = (push && !pop) ? ((state_q == EMPTY) ? ONE : TWO) :
                (pop && !push) ? ((state_q == TWO) ? ONE : EMPTY) : state_q;
      cnt_d = cnt_q + {31'd0, pop};
      if (pop) ent_d[0] = ent_q[1];
      if (push) ent_d[slot] = dec;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_op = ent_q[0].op;
  assign out_rd = ent_q[0].rd;
  assign out_rs1 = ent_q[0].rs1;
  assign out_rs2 = ent_q[0].rs2;
  assign out_imm = ent_q[0].imm;
  assign out_pc = ent_q[0].pc;
  assign out_illegal = ent_q[0].illegal;
  assign decoded_count = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus backpressure, flush and reset sequences for decode_stage.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_insn, decoded_count;
  logic [63:0] in_pc, out_imm, out_pc;
  logic [5:0] out_op;
  logic [4:0] out_rd, out_rs1, out_rs2;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;
  typedef struct {
    logic [31:0] insn;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        ill;
  } vec_t;
  vec_t vecs [14];
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
    .decoded_count(decoded_count)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] insn, input logic [5:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm);
    vec_t v;
    v.insn = insn; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.ill = (op == 6'd0);
    return v;
  endfunction
  task automatic push_one(input logic [31:0] insn, input logic [63:0] pc);
    in_valid = 1'b1; in_insn = insn; in_pc = pc;
    tick;
    in_valid = 1'b0;
  endtask
  initial begin
    vecs[0]  = mk(32'h00500093, 6'd5,  5'd1,  5'd0, 5'd0, 64'd5);
    vecs[1]  = mk(32'h12345137, 6'd1,  5'd2,  5'd0, 5'd0, 64'h0000000012345000);
    vecs[2]  = mk(32'h43F0D193, 6'd13, 5'd3,  5'd1, 5'd0, 64'd63);
`ifdef RV64M_EN
    vecs[3]  = mk(32'h02208233, 6'd33, 5'd4,  5'd1, 5'd2, 64'd0);
    vecs[12] = mk(32'h023170BB, 6'd45, 5'd1,  5'd2, 5'd3, 64'd0);
`else
    vecs[3]  = mk(32'h02208233, 6'd0,  5'd0,  5'd0, 5'd0, 64'd0);
    vecs[12] = mk(32'h023170BB, 6'd0,  5'd0,  5'd0, 5'd0, 64'd0);
`endif
    vecs[4]  = mk(32'h00000000, 6'd0,  5'd0,  5'd0, 5'd0, 64'd0);
    vecs[5]  = mk(32'h407302B3, 6'd15, 5'd5,  5'd6, 5'd7, 64'd0);
    vecs[6]  = mk(32'hFFFFF517, 6'd2,  5'd10, 5'd0, 5'd0, 64'hFFFFFFFFFFFFF000);
    vecs[7]  = mk(32'hFFF00093, 6'd5,  5'd1,  5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFF);
    vecs[8]  = mk(32'h008000EF, 6'd3,  5'd1,  5'd0, 5'd0, 64'd8);
    vecs[9]  = mk(32'h0210909B, 6'd0,  5'd0,  5'd0, 5'd0, 64'd0);
    vecs[10] = mk(32'h4051D11B, 6'd27, 5'd2,  5'd3, 5'd0, 64'd5);
    vecs[11] = mk(32'h00500090, 6'd0,  5'd0,  5'd0, 5'd0, 64'd0);
    vecs[13] = mk(32'h000010E7, 6'd0,  5'd0,  5'd0, 5'd0, 64'd0);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_insn = '0; in_pc = '0;
    tick;
    tick;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst count", 64'(decoded_count), 64'd0);
    chk("rst out_op", 64'(out_op), 64'd0);
    chk("rst out_imm", out_imm, 64'd0);
    chk("rst out_pc", out_pc, 64'd0);
    chk("rst out_illegal", 64'(out_illegal), 64'd0);
    reset = 1'b0;
    tick;
    chk("post-rst in_ready", 64'(in_ready), 64'd1);
    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      push_one(vecs[i].insn, 64'h1000 + 64'(4 * i));
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d op", i), 64'(out_op), 64'(vecs[i].op));
      chk($sformatf("v%0d rd", i), 64'(out_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d rs1", i), 64'(out_rs1), 64'(vecs[i].rs1));
      chk($sformatf("v%0d rs2", i), 64'(out_rs2), 64'(vecs[i].rs2));
      chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d pc", i), out_pc, 64'h1000 + 64'(4 * i));
      chk($sformatf("v%0d illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      exp_cnt++;
      chk($sformatf("v%0d drained", i), 64'(out_valid), 64'd0);
      chk($sformatf("v%0d count", i), 64'(decoded_count), 64'(exp_cnt));
    end
    // backpressure: three back-to-back pushes with out_ready low
    in_valid = 1'b1; in_insn = 32'h00500093; in_pc = 64'h2000;
    tick;
    chk("bp in_ready c1", 64'(in_ready), 64'd1);
    in_insn = 32'h12345137; in_pc = 64'h2004;
    tick;
    chk("bp in_ready c2", 64'(in_ready), 64'd0);
    in_insn = 32'h407302B3; in_pc = 64'h2008;
    tick;
    chk("bp in_ready c3", 64'(in_ready), 64'd0);
    chk("bp head stable op", 64'(out_op), 64'd5);
    chk("bp head stable pc", out_pc, 64'h2000);
    chk("bp count held", 64'(decoded_count), 64'(exp_cnt));
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    chk("bp 2nd op", 64'(out_op), 64'd1);
    chk("bp 2nd pc", out_pc, 64'h2004);
    chk("bp in_ready after pop", 64'(in_ready), 64'd1);
    tick;
    exp_cnt += 2;
    chk("bp empty", 64'(out_valid), 64'd0);
    chk("bp count", 64'(decoded_count), 64'(exp_cnt));
    // streaming: simultaneous push and pop while holding one entry
    in_valid = 1'b1; in_insn = 32'h00500093; in_pc = 64'h3000;
    tick;
    in_insn = 32'h12345137; in_pc = 64'h3004;
    tick;
    chk("stream 2nd op", 64'(out_op), 64'd1);
    chk("stream in_ready", 64'(in_ready), 64'd1);
    in_insn = 32'h00000000; in_pc = 64'h3008;
    tick;
    chk("stream 3rd illegal", 64'(out_illegal), 64'd1);
    chk("stream 3rd pc", out_pc, 64'h3008);
    in_valid = 1'b0;
    tick;
    exp_cnt += 3;
    chk("stream empty", 64'(out_valid), 64'd0);
    chk("stream count", 64'(decoded_count), 64'(exp_cnt));
    // flush from TWO with a concurrent push and pop attempt
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = 32'h00500093;
    tick;
    tick;
    chk("fl full", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl out_valid", 64'(out_valid), 64'd0);
    chk("fl in_ready", 64'(in_ready), 64'd1);
    chk("fl count", 64'(decoded_count), 64'(exp_cnt));
    tick;
    chk("fl stays empty", 64'(out_valid), 64'd0);
    // reset overrides flush and an in-flight handshake
    push_one(32'h12345137, 64'h4000);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mid-rst out_valid", 64'(out_valid), 64'd0);
    chk("mid-rst count", 64'(decoded_count), 64'd0);
    chk("mid-rst out_op", 64'(out_op), 64'd0);
    chk("mid-rst out_pc", out_pc, 64'd0);
    tick;
    chk("mid-rst in_ready", 64'(in_ready), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
